// File: rtl/cuadrado_seq_raiz.sv
// rtl/cuadrado_seq_raiz.sv - shift-and-add squaring unit for the root inverse check
// Optional radicand comparator enabled by defining RAIZ_CHECK_EN.
module cuadrado_seq_raiz #(
    parameter int W = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           INIT,
    input  logic [W-1:0]   A,
    output logic [2*W-1:0] PP,
    output logic           BUSY,
    output logic           DONE
`ifdef RAIZ_CHECK_EN
    ,
    input  logic [2*W-1:0] RADICANDO,
    output logic           EXACTA,
    output logic           MAYOR
`endif
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state, next_state;

    logic [2*W-1:0] acc;
    logic [2*W-1:0] md;
    logic [W-1:0]   b;
    logic [CW-1:0]  cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (INIT) next_state = RUN;
            RUN:     if (cnt == CW'(1)) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // BUSY drops in the same edge that raises DONE, since FIN always returns to IDLE
    assign BUSY = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc  <= '0;
            md   <= '0;
            b    <= '0;
            cnt  <= '0;
            PP   <= '0;
            DONE <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (INIT) begin
                        md  <= {{W{1'b0}}, A};
                        b   <= A;
                        acc <= '0;
                        cnt <= CW'(W);
                    end
                end
                RUN: begin
                    // the product of two W-bit values always fits in 2W bits
                    if (b[0]) acc <= acc + md;
                    md  <= md << 1;
                    b   <= b >> 1;
                    cnt <= cnt - 1'b1;
                end
                FIN: begin
                    PP   <= acc;
                    DONE <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef RAIZ_CHECK_EN
    logic [2*W-1:0] rad;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rad    <= '0;
            EXACTA <= 1'b0;
            MAYOR  <= 1'b0;
        end else begin
            if (state == IDLE && INIT) rad <= RADICANDO;
            if (state == FIN) begin
                EXACTA <= (acc == rad);
                MAYOR  <= (acc > rad);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cuadrado_seq_raiz.sv
// tb/tb_cuadrado_seq_raiz.sv - self-checking bench for cuadrado_seq_raiz
// Exercises the RAIZ_CHECK_EN flags only when that macro is defined.
module tb_cuadrado_seq_raiz;

    localparam int W = 16;
    localparam int LAT = W + 1;

    logic           CLK = 1'b0;
    logic           RST;
    logic           INIT;
    logic [W-1:0]   A;
    logic [2*W-1:0] PP;
    logic           BUSY;
    logic           DONE;
`ifdef RAIZ_CHECK_EN
    logic [2*W-1:0] RADICANDO;
    logic           EXACTA;
    logic           MAYOR;
`endif

    int errors = 0;
    int checks = 0;
    int cyc;
    int busy_n;
    int done_n;

    cuadrado_seq_raiz #(.W(W)) dut (
        .CLK(CLK),
        .RST(RST),
        .INIT(INIT),
        .A(A),
        .PP(PP),
        .BUSY(BUSY),
        .DONE(DONE)
`ifdef RAIZ_CHECK_EN
        ,
        .RADICANDO(RADICANDO),
        .EXACTA(EXACTA),
        .MAYOR(MAYOR)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [2*W-1:0] square(input logic [W-1:0] x);
        int unsigned v;
        v = int'(x);
        return 32'(v * v);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (BUSY) busy_n++;
        if (DONE) done_n++;
    endtask

    // Drives INIT across one edge (edge 0) and restarts the cycle counters there
    task automatic start(input logic [W-1:0] a);
        A = a;
        INIT = 1'b1;
        @(posedge CLK);
        #1;
        INIT = 1'b0;
        cyc = 0;
        busy_n = BUSY ? 1 : 0;
        done_n = 0;
    endtask

    task automatic wait_done();
        while (!DONE && cyc < 60) tick();
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [W-1:0] a_val;

    initial begin
        RST = 1'b1;
        INIT = 1'b0;
        A = '0;
`ifdef RAIZ_CHECK_EN
        RADICANDO = '0;
`endif
        cyc = 0;
        busy_n = 0;
        done_n = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_pp", 64'(PP), 64'd0);
        check("reset_busy", 64'(BUSY), 64'd0);
        check("reset_done", 64'(DONE), 64'd0);
`ifdef RAIZ_CHECK_EN
        check("reset_exacta", 64'(EXACTA), 64'd0);
        check("reset_mayor", 64'(MAYOR), 64'd0);
`endif
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // A = 0 still takes the full latency
        start(16'd0);
        check("zero_busy_after_init", 64'(BUSY), 64'd1);
        wait_done();
        check("zero_done_edge", 64'(cyc), 64'(LAT));
        check("zero_pp", 64'(PP), 64'd0);
        check("zero_busy_at_done", 64'(BUSY), 64'd0);
        settle(5);
        check("zero_busy_cycles", 64'(busy_n), 64'(LAT));
        check("zero_done_count", 64'(done_n), 64'd1);
        check("zero_pp_hold", 64'(PP), 64'd0);

        start(16'd255);
        wait_done();
        check("a255_pp", 64'(PP), 64'h0000_FE01);
        tick();
        check("a255_done_one_cycle", 64'(DONE), 64'd0);
        check("a255_pp_hold", 64'(PP), 64'h0000_FE01);

        start(16'hFFFF);
        wait_done();
        check("a65535_edge", 64'(cyc), 64'(LAT));
        check("a65535_pp", 64'(PP), 64'hFFFE_0001);
        settle(3);

        // Mid-run INIT and operand change must be ignored
        start(16'd12);
        settle(4);
        A = 16'd99;
        INIT = 1'b1;
        tick();
        INIT = 1'b0;
        check("ign_busy", 64'(BUSY), 64'd1);
        wait_done();
        check("ign_done_edge", 64'(cyc), 64'(LAT));
        check("ign_pp", 64'(PP), 64'd144);
        settle(25);
        check("ign_done_count", 64'(done_n), 64'd1);
        check("ign_busy_cycles", 64'(busy_n), 64'(LAT));

        // Randomized operands with disturbance during RUN
        for (int k = 0; k < 8; k++) begin
            a_val = W'($urandom);
            start(a_val);
            settle(1 + int'($urandom_range(0, 10)));
            A = W'($urandom);
            INIT = 1'b1;
            tick();
            INIT = 1'b0;
            wait_done();
            check("rnd_edge", 64'(cyc), 64'(LAT));
            check("rnd_pp", 64'(PP), 64'(square(a_val)));
            settle(2);
        end

        // Asynchronous abort at cycle 8
        start(16'd300);
        settle(7);
        RST = 1'b1;
        #1;
        check("abort_pp", 64'(PP), 64'd0);
        check("abort_busy", 64'(BUSY), 64'd0);
        check("abort_done", 64'(DONE), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        done_n = 0;
        settle(25);
        check("abort_no_done", 64'(done_n), 64'd0);
        check("abort_pp_hold", 64'(PP), 64'd0);
        start(16'd3);
        wait_done();
        check("after_abort_pp", 64'(PP), 64'd9);
        settle(2);

        // Back-to-back: second INIT taken in the DONE cycle
        start(16'd7);
        wait_done();
        check("b2b_first_pp", 64'(PP), 64'd49);
        start(16'd8);
        check("b2b_busy_restart", 64'(BUSY), 64'd1);
        wait_done();
        check("b2b_second_gap", 64'(cyc + 1), 64'(LAT + 1));
        check("b2b_second_pp", 64'(PP), 64'd64);
        settle(2);

`ifdef RAIZ_CHECK_EN
        RADICANDO = 32'd144;
        start(16'd12);
        RADICANDO = 32'd0;
        wait_done();
        check("chk_eq_exacta", 64'(EXACTA), 64'd1);
        check("chk_eq_mayor", 64'(MAYOR), 64'd0);
        RADICANDO = 32'd145;
        start(16'd12);
        wait_done();
        check("chk_lt_exacta", 64'(EXACTA), 64'd0);
        check("chk_lt_mayor", 64'(MAYOR), 64'd0);
        RADICANDO = 32'd143;
        start(16'd12);
        wait_done();
        check("chk_gt_exacta", 64'(EXACTA), 64'd0);
        check("chk_gt_mayor", 64'(MAYOR), 64'd1);
        settle(3);
        check("chk_hold_mayor", 64'(MAYOR), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cuadrado_seq_raiz.md
# cuadrado_seq_raiz

Sequential squaring unit for the calculator's square-root path: takes the 16-bit root candidate held by the root temp register and computes its exact 32-bit square with a shift-and-add multiplier. The root datapath uses it as the inverse check: once a root R is produced, the block returns R², so the result can be compared against the original radicand. Start/done handshake, fixed latency, one multiplier bit per clock.

## Interface
- W, 16: operand width; result is 2W bits.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- INIT  input  1  start pulse; sampled only in IDLE.
- A  input  W  operand to square, normally the root temp register output.
- PP  output  2W  registered result A²; holds until the next completion.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse when PP has been updated.
- RADICANDO  input  2W  radicand to check against; present only with RAIZ_CHECK_EN.
- EXACTA  output  1  PP == latched radicand; present only with RAIZ_CHECK_EN.
- MAYOR  output  1  PP > latched radicand; present only with RAIZ_CHECK_EN.

## Operation
- States: IDLE, RUN, FIN.
- IDLE: BUSY=0. On INIT=1:
  - latch MD <= {W'0, A} and B <= A;
  - clear ACC, set CNT <= W;
  - go to RUN.
- RUN: BUSY=1. Each clock:
  - if B[0]: ACC <= ACC + MD (2W-bit add, no carry-out possible);
  - MD <= MD << 1, B <= B >> 1, CNT <= CNT - 1;
  - when CNT == 1 on this edge, go to FIN.
- FIN: PP <= ACC, DONE <= 1, BUSY <= 0, go to IDLE. Single cycle.
- INIT in RUN or FIN is ignored; it does not queue or restart.
- A is sampled only at the INIT edge. Changes on A during RUN have no effect.
- No early termination: every operation takes W iterations, including A=0.
- PP keeps its last value across IDLE periods. It changes only in FIN or on reset.

## Timing
- Reset values: PP=0, DONE=0, BUSY=0, state IDLE, ACC/MD/B/CNT=0; EXACTA=0, MAYOR=0 when compiled in.
- Edge 0 samples INIT: state becomes RUN and BUSY goes high after edge 0.
- Edges 1..W perform the iterations.
- Edge W+1 (FIN) writes PP and sets DONE.
- DONE is high for exactly the cycle between edges W+1 and W+2.
- BUSY is high from after edge 0 until edge W+1.
- INIT may be asserted in the cycle DONE is high: the block is in IDLE, so it is accepted. Minimum throughput is one result per W+2 cycles.
- Reset asserted mid-operation aborts immediately. Everything returns to reset values, and no DONE is produced for the aborted operation.
- INIT held high continuously restarts a new operation every W+2 cycles.

## Configuration
- RAIZ_CHECK_EN defined:
  - RADICANDO is latched at the INIT edge together with A.
  - At the FIN edge, EXACTA <= (ACC == radicand) and MAYOR <= (ACC > radicand), updated in the same edge as PP/DONE.
  - Both flags hold until the next FIN or reset.
- RAIZ_CHECK_EN not defined:
  - RADICANDO, EXACTA and MAYOR ports, the radicand latch and the comparator are absent.
  - Everything else is identical.

## Test plan
- Reset then A=0, INIT pulse -> BUSY for 17 cycles, DONE at edge 17, PP=0x00000000; PP holds 0 afterwards.
- A=255, INIT -> PP=65025 (0x0000FE01) with DONE one cycle. Then A=65535, INIT -> PP=0xFFFE0001.
- A=12, INIT; at cycle 5 change A to 99 and pulse INIT again -> PP=144, single DONE, second INIT ignored, BUSY unchanged.
- A=300, INIT; assert RST at cycle 8 for 1 cycle -> PP=0, BUSY=0, no DONE. Then A=3, INIT -> PP=9.
- Back-to-back: INIT A=7, and INIT A=8 in the DONE cycle -> PP=49 with DONE, then PP=64 with DONE 18 cycles later.
- RAIZ_CHECK_EN: A=12 with RADICANDO=144 -> EXACTA=1, MAYOR=0; RADICANDO=145 -> EXACTA=0, MAYOR=0; RADICANDO=143 -> EXACTA=0, MAYOR=1.
